// File: rtl/mult_arbiter.sv
// Round-robin arbiter that lends one shift-and-add multiplier core to NREQ requesters,
// sequencing the core's start/done handshake with a timeout and pulsing the result back.
module mult_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 256,
   parameter int CW      = 9
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   opa,
   input  logic [NREQ*WIDTH-1:0]   opb,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         done_out,
   output logic [NREQ-1:0]         timeout_err,
   output logic [2*WIDTH-1:0]      result_out,
   output logic                    busy,
   output logic [WIDTH-1:0]        mult_a,
   output logic [WIDTH-1:0]        mult_b,
   output logic                    mult_start,
   input  logic                    mult_done,
   input  logic [2*WIDTH-1:0]      mult_result
);

   localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]           state_reg;
   logic [NREQ-1:0]      grant_reg;
   logic [NREQ-1:0]      done_reg;
   logic [NREQ-1:0]      terr_reg;
   logic [2*WIDTH-1:0]   result_reg;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   logic                 start_reg;
   logic [IW-1:0]        rr_reg;
   logic [IW-1:0]        owner_reg;
   logic [CW-1:0]        cnt_reg;

   logic [WIDTH-1:0]     opa_arr [NREQ];
   logic [WIDTH-1:0]     opb_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign opa_arr[gi] = opa[gi*WIDTH +: WIDTH];
         assign opb_arr[gi] = opb[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // First requester at or after the rr pointer, wrapping past NREQ-1.
   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [IW:0]   scan_idx;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, rr_reg} + (IW+1)'(k);
         if (scan_idx >= (IW+1)'(NREQ)) begin
            scan_idx = scan_idx - (IW+1)'(NREQ);
         end
         if (!win_found && req[scan_idx[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         grant_reg  <= '0;
         done_reg   <= '0;
         terr_reg   <= '0;
         result_reg <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         start_reg  <= 1'b0;
         rr_reg     <= '0;
         owner_reg  <= '0;
         cnt_reg    <= '0;
      end else begin
         start_reg <= 1'b0;
         done_reg  <= '0;
         terr_reg  <= '0;
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  a_reg     <= opa_arr[win_idx];
                  b_reg     <= opb_arr[win_idx];
                  grant_reg <= NREQ'(1) << win_idx;
                  owner_reg <= win_idx;
                  start_reg <= 1'b1;
                  state_reg <= START;
               end
            end
            START: begin
               cnt_reg   <= '0;
               state_reg <= BUSY;
            end
            BUSY: begin
               cnt_reg <= cnt_reg + 1'b1;
               // A done arriving on the last allowed cycle still counts as success.
               if (mult_done) begin
                  result_reg <= mult_result;
                  done_reg   <= grant_reg;
                  state_reg  <= DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  terr_reg  <= grant_reg;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               rr_reg    <= (owner_reg == IW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
               grant_reg <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign grant       = grant_reg;
   assign done_out    = done_reg;
   assign timeout_err = terr_reg;
   assign result_out  = result_reg;
   assign busy        = (state_reg != IDLE);
   assign mult_a      = a_reg;
   assign mult_b      = b_reg;
   assign mult_start  = start_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: acts as requesters and as the multiplier core, and checks
// each operation against a transaction-level round-robin model.
module tb_mult_arbiter;

   localparam int W  = 8;
   localparam int N  = 2;
   localparam int TO = 16;
   localparam int CW = 5;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N-1:0]     req;
   logic [N*W-1:0]   opa;
   logic [N*W-1:0]   opb;
   logic [N-1:0]     grant;
   logic [N-1:0]     done_out;
   logic [N-1:0]     timeout_err;
   logic [2*W-1:0]   result_out;
   logic             busy;
   logic [W-1:0]     mult_a;
   logic [W-1:0]     mult_b;
   logic             mult_start;
   logic             mult_done;
   logic [2*W-1:0]   mult_result;

   int               total = 0;
   int               bad = 0;
   int               ptr_m = 0;
   logic [2*W-1:0]   result_m = '0;

   mult_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO), .CW(CW)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .opa(opa), .opb(opb),
      .grant(grant), .done_out(done_out), .timeout_err(timeout_err),
      .result_out(result_out), .busy(busy), .mult_a(mult_a), .mult_b(mult_b),
      .mult_start(mult_start), .mult_done(mult_done), .mult_result(mult_result)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int w);
      return 32'(1) << w;
   endfunction

   // Round-robin rule: first requesting index starting at p, wrapping modulo N.
   function automatic int rr_pick(input int p, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // One request/response transaction; the core answers d BUSY cycles in (d >= TO means never).
   task automatic do_op(input logic [N-1:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int d, input bit drop, input bit stale);
      int w;
      bit ok;
      logic [2*W-1:0] p;
      w = rr_pick(ptr_m, r);
      p = 16'(a) * 16'(b);
      opa = N*W'($urandom);
      opb = N*W'($urandom);
      if (w >= 0) begin
         opa[w*W +: W] = a;
         opb[w*W +: W] = b;
      end
      req = r;
      mult_done = 1'b0;
      step();
      if (w < 0) begin
         chk("idle_grant", 32'(grant), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_start", 32'(mult_start), 32'd0);
         $display("op req=%b idle", r);
         return;
      end
      chk("start_grant", 32'(grant), oh(w));
      chk("start_pulse", 32'(mult_start), 32'd1);
      chk("start_mult_a", 32'(mult_a), 32'(a));
      chk("start_mult_b", 32'(mult_b), 32'(b));
      chk("start_busy", 32'(busy), 32'd1);
      opa[w*W +: W] = ~a;
      opb[w*W +: W] = ~b;
      if (drop) req = '0;
      if (stale) begin
         mult_done = 1'b1;
         mult_result = 16'($urandom);
      end
      step();
      for (int j = 0; j < TO; j++) begin
         chk("busy_start", 32'(mult_start), 32'd0);
         chk("busy_grant", 32'(grant), oh(w));
         chk("busy_mult_a", 32'(mult_a), 32'(a));
         chk("busy_pulse", 32'({done_out, timeout_err}), 32'd0);
         if (j == d) begin
            mult_done = 1'b1;
            mult_result = p;
         end else begin
            mult_done = 1'b0;
            mult_result = 16'($urandom);
         end
         step();
         if (j == d) break;
      end
      mult_done = 1'b0;
      ok = (d <= TO - 1);
      if (ok) result_m = p;
      chk("done_out", 32'(done_out), ok ? oh(w) : 32'd0);
      chk("timeout_err", 32'(timeout_err), ok ? 32'd0 : oh(w));
      chk("done_result", 32'(result_out), 32'(result_m));
      chk("done_grant", 32'(grant), oh(w));
      step();
      chk("end_grant", 32'(grant), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_pulse", 32'({done_out, timeout_err}), 32'd0);
      chk("end_result", 32'(result_out), 32'(result_m));
      ptr_m = (w + 1) % N;
      $display("op req=%b owner=%0d a=%0d b=%0d d=%0d ok=%0d result=%0h", r, w, a, b, d, ok, result_out);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_done"}, 32'(done_out), 32'd0);
      chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
      chk({tag, "_result"}, 32'(result_out), 32'd0);
      chk({tag, "_mult_a"}, 32'(mult_a), 32'd0);
      chk({tag, "_mult_b"}, 32'(mult_b), 32'd0);
      chk({tag, "_start"}, 32'(mult_start), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int d;
      int sel;
      reset_n = 1'b0;
      req = '0;
      opa = '0;
      opb = '0;
      mult_done = 1'b0;
      mult_result = '0;
      step();
      step();
      chk_all_zero("reset");
      $display("reset state checked");
      reset_n = 1'b1;

      // Contention with both held: 0, 1, 0.
      do_op(2'b11, 8'd3, 8'd4, 2, 1'b0, 1'b0);
      do_op(2'b11, 8'd5, 8'd6, 4, 1'b0, 1'b0);
      do_op(2'b11, 8'd7, 8'd8, 1, 1'b0, 1'b0);
      // Single op with stale done in START and operand change while busy.
      do_op(2'b01, 8'd13, 8'd11, 8, 1'b0, 1'b1);
      do_op(2'b01, 8'd5, 8'd9, 3, 1'b1, 1'b0);
      // Timeout, then coincident done on the final BUSY cycle.
      do_op(2'b10, 8'd200, 8'd200, 1000, 1'b0, 1'b0);
      do_op(2'b10, 8'd17, 8'd19, TO - 1, 1'b0, 1'b0);
      do_op(2'b00, 8'd1, 8'd1, 0, 1'b0, 1'b0);

      // Reset mid-BUSY after requester 0 leaves the pointer at 1.
      do_op(2'b01, 8'd2, 8'd2, 0, 1'b0, 1'b0);
      req = 2'b10;
      opa = 16'h0900;
      opb = 16'h0a00;
      step();
      chk("rst_pre_grant", 32'(grant), 32'd2);
      step();
      step();
      step();
      reset_n = 1'b0;
      req = '0;
      step();
      chk_all_zero("midrst");
      reset_n = 1'b1;
      mult_done = 1'b1;
      mult_result = 16'hbeef;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all_zero("stale");
      end
      mult_done = 1'b0;
      ptr_m = 0;
      result_m = '0;
      $display("mid-busy reset checked");
      do_op(2'b11, 8'd21, 8'd3, 2, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0) d = 1000;
         else if (sel == 1) d = TO - 1;
         else d = int'($urandom_range(0, 8));
         do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), d,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one shift-and-add multiplier core between NREQ independent requesters, e.g. two SPI multiplier peripherals on one die. Arbitrates with round-robin priority and latches the winner's operands into the core. Sequences the core's start/done handshake, guards it with a timeout counter, and returns the product with a one-cycle completion pulse to the granted requester. Sits between the SPI-side FSMs and the multiplier datapath.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH.
NREQ, 2, number of requesters (2..4).
TIMEOUT, 256, max cycles in BUSY before abort; minimum 2.
CW, 9, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  synchronous, active-low reset.
req  input  NREQ  per-requester request level.
opa  input  NREQ*WIDTH  flattened operand A; slice i belongs to requester i.
opb  input  NREQ*WIDTH  flattened operand B; slice i belongs to requester i.
grant  output  NREQ  one-hot ownership of the multiplier.
done_out  output  NREQ  one-cycle completion pulse to the owner.
timeout_err  output  NREQ  one-cycle abort pulse to the owner.
result_out  output  2*WIDTH  registered product of the last successful operation.
busy  output  1  high whenever state is not IDLE.
mult_a  output  WIDTH  operand A to the core, registered.
mult_b  output  WIDTH  operand B to the core, registered.
mult_start  output  1  one-cycle start pulse to the core.
mult_done  input  1  core completion flag; level or pulse accepted.
mult_result  input  2*WIDTH  core product; valid when mult_done is high.

Behaviour:
- Reset (reset_n low at a clock edge): state=IDLE, grant=0, done_out=0, timeout_err=0, result_out=0, mult_a=0, mult_b=0, mult_start=0, busy=0, rr pointer=0, counter=0. Reset mid-operation aborts silently with no done_out or timeout_err pulse. Later core activity is ignored until a new START.
- States:
  - IDLE: evaluate req. Winner is the first set bit scanning from the rr pointer upward with wrap. If there is a winner, latch mult_a/mult_b from the winner's slices, set grant to the one-hot winner, and go to START. With no req, stay in IDLE.
  - START: mult_start=1 for exactly this cycle; counter cleared; go to BUSY. mult_done seen in START is ignored (stale).
  - BUSY: counter increments each cycle.
    - If mult_done=1: capture mult_result into result_out; go to DONE with ok.
    - Else if counter==TIMEOUT-1: go to DONE with err; result_out is unchanged.
    - If mult_done and the timeout coincide, mult_done wins.
  - DONE: done_out[owner]=1 (ok) or timeout_err[owner]=1 (err) for this cycle only. grant is still high. rr pointer becomes owner+1 (mod NREQ). Go to IDLE; grant clears on the next edge.
- Latency:
  - req sampled high at edge 0 gives grant and mult_start high after edge 0 (cycle 1).
  - BUSY starts at cycle 2.
  - mult_done sampled at edge k gives result_out and done_out valid at cycle k+1.
  - grant goes low at cycle k+2; the earliest next grant is cycle k+3.
- Operands are captured only in IDLE. Changes on opa/opb while granted have no effect.
- Dropping req while granted does not abort. The operation completes and pulses to that requester.
- A req still held through IDLE is a new request. Round-robin rotation gives any other pending requester priority first.
- busy = (state != IDLE). Exactly one grant bit is high in START, BUSY and DONE; all grant bits are 0 in IDLE.
- done_out and timeout_err are never both high. Only the owner's bit can pulse.

Test Plan:
- Single op: req=01, opa[0]=13, opb[0]=11, core asserts mult_done with 143 after 9 cycles -> grant=01 at cycle 1, mult_start pulse at cycle 1 only, done_out=01 one cycle, result_out=143, grant=00 two cycles after done.
- Contention: req=11 held, pointer=0 -> requester 0 served first, then requester 1, then requester 0 again; grants alternate 01,10,01 with no overlap and busy low for exactly one cycle between ops.
- Timeout: TIMEOUT=16, req=10, core never asserts done -> timeout_err=10 for one cycle after 16 BUSY cycles, done_out stays 00, result_out keeps its previous value, next req is granted normally.
- Coincident done and timeout on the final BUSY cycle -> done_out pulses, timeout_err stays 0, result captured.
- Reset mid-BUSY: reset_n low for 1 cycle -> all outputs 0 next cycle, no pulses; a stale mult_done afterwards is ignored; the next req starts at requester 0 priority.
- Operand stability: change opa[0] from 5 to 7 during BUSY -> mult_a stays 5 until the operation ends.
